// File: rtl/game_pkg.sv
// Shared types and helpers for the light-cycle game.
// Direction encoding, player key maps and the scheduler states.
package game_pkg;

    typedef enum logic [2:0] {
        WAIT  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } directions;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } sched_state_t;

    // Player 1: W/S/A/D make codes (PS/2 set 2)
    localparam logic [7:0] P1_KEY_UP    = 8'h1D;
    localparam logic [7:0] P1_KEY_DOWN  = 8'h1B;
    localparam logic [7:0] P1_KEY_LEFT  = 8'h1C;
    localparam logic [7:0] P1_KEY_RIGHT = 8'h23;

    // Player 2: arrow-key make codes (E0-prefixed in the stream)
    localparam logic [7:0] P2_KEY_UP    = 8'h75;
    localparam logic [7:0] P2_KEY_DOWN  = 8'h72;
    localparam logic [7:0] P2_KEY_LEFT  = 8'h6B;
    localparam logic [7:0] P2_KEY_RIGHT = 8'h74;

    // Reverse of a heading; WAIT has no reverse
    function automatic directions opposite(input directions d);
        directions r;
        r = WAIT;
        unique case (d)
            UP:      r = DOWN;
            DOWN:    r = UP;
            LEFT:    r = RIGHT;
            RIGHT:   r = LEFT;
            default: r = WAIT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Movement tick counter: counts 0..TICK_CYCLES-1 while enabled.
// tc marks the last cycle of each window; clr parks it at zero.
module tick_gen #(
    parameter int TICK_CYCLES = 6_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(TICK_CYCLES);
    localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, else wrap at the last cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = en & (cnt_q == LAST);

endmodule

// File: rtl/move_scheduler.sv
// Turns key events into one-clock movement commands per tick.
// Enforces forward motion, no reversal and freeze on collision.
module move_scheduler
    import game_pkg::*;
#(
    parameter int         TICK_CYCLES = 6_500_000,
    parameter logic [7:0] KEY_UP      = P1_KEY_UP,
    parameter logic [7:0] KEY_DOWN    = P1_KEY_DOWN,
    parameter logic [7:0] KEY_LEFT    = P1_KEY_LEFT,
    parameter logic [7:0] KEY_RIGHT   = P1_KEY_RIGHT,
    parameter directions  INIT_DIR    = RIGHT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_break,
    input  logic       game_active,
    input  logic       collision,
    output directions  direction,
    output directions  heading,
    output logic       step,
    output logic       halted
);

    sched_state_t state_q, state_d;
    directions    heading_q, heading_d;
    directions    pend_dir_q, pend_dir_d;
    logic         pend_v_q, pend_v_d;
    directions    dir_q, dir_d;
    logic         step_q, step_d;

    directions    req_dir;
    directions    new_head;
    logic         accept;
    logic         tc;
    logic         cnt_clr;
    logic         cnt_en;

    assign cnt_clr = (state_q == IDLE);
    assign cnt_en  = (state_q == RUN);

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .en (cnt_en),
        .tc (tc)
    );

    // Map a make code onto a direction; anything else is no request
    always_comb begin
        req_dir = WAIT;
        if (key_valid && !key_break) begin
            unique case (1'b1)
                (key_code == KEY_UP):    req_dir = UP;
                (key_code == KEY_DOWN):  req_dir = DOWN;
                (key_code == KEY_LEFT):  req_dir = LEFT;
                (key_code == KEY_RIGHT): req_dir = RIGHT;
                default:                 req_dir = WAIT;
            endcase
        end
    end

    // Reversal is judged against the committed heading, not pending
    assign accept = (req_dir != WAIT) &&
                    (req_dir != opposite(heading_q));

    // Next state, pending request and registered step outputs
    always_comb begin
        state_d    = state_q;
        heading_d  = heading_q;
        pend_dir_d = pend_dir_q;
        pend_v_d   = pend_v_q;
        dir_d      = WAIT;
        step_d     = 1'b0;
        new_head   = heading_q;
        if (accept) begin
            new_head = req_dir;
        end else if (pend_v_q) begin
            new_head = pend_dir_q;
        end
        unique case (state_q)
            IDLE: begin
                heading_d = INIT_DIR;
                pend_v_d  = 1'b0;
                if (game_active) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!game_active) begin
                    state_d   = IDLE;
                    heading_d = INIT_DIR;
                    pend_v_d  = 1'b0;
                end else if (collision) begin
                    state_d = HALT;
                end else if (tc) begin
                    heading_d = new_head;
                    pend_v_d  = 1'b0;
                    dir_d     = new_head;
                    step_d    = 1'b1;
                end else if (accept) begin
                    pend_dir_d = req_dir;
                    pend_v_d   = 1'b1;
                end
            end
            HALT: begin
                if (!game_active) begin
                    state_d   = IDLE;
                    heading_d = INIT_DIR;
                    pend_v_d  = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                heading_d = INIT_DIR;
                pend_v_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            heading_q  <= INIT_DIR;
            pend_dir_q <= WAIT;
            pend_v_q   <= 1'b0;
            dir_q      <= WAIT;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            heading_q  <= heading_d;
            pend_dir_q <= pend_dir_d;
            pend_v_q   <= pend_v_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
        end
    end

    assign direction = dir_q;
    assign heading   = heading_q;
    assign step      = step_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler with a 4-clock tick window.
// Table of per-window key patterns plus collision/reset sequences.
module tb_move_scheduler;
    import game_pkg::*;

    localparam int N = 4;
    localparam logic [7:0] KU = 8'h1D;
    localparam logic [7:0] KD = 8'h1B;
    localparam logic [7:0] KL = 8'h1C;
    localparam logic [7:0] KR = 8'h23;
    localparam logic [7:0] KX = 8'h55;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_break;
    logic       game_active;
    logic       collision;
    directions  direction;
    directions  heading;
    logic       step;
    logic       halted;

    int n_chk = 0;
    int n_fail = 0;
    directions sb_q[$];

    typedef struct {
        logic [3:0]      vld;
        logic [3:0]      brk;
        logic [3:0][7:0] code;
        directions       exp;
    } win_t;

    win_t tbl[18];

    always #5 clk = ~clk;

    move_scheduler #(
        .TICK_CYCLES(N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_break  (key_break),
        .game_active(game_active),
        .collision  (collision),
        .direction  (direction),
        .heading    (heading),
        .step       (step),
        .halted     (halted)
    );

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic win_t mk(input logic [3:0] vld,
                                input logic [3:0] brk,
                                input logic [7:0] c0,
                                input logic [7:0] c1,
                                input logic [7:0] c2,
                                input logic [7:0] c3,
                                input directions exp);
        win_t w;
        w.vld  = vld;
        w.brk  = brk;
        w.code = {c3, c2, c1, c0};
        w.exp  = exp;
        return w;
    endfunction

    // One tick window starting at counter==0; step seen after it
    task automatic run_window(input win_t w, input int idx);
        directions e;
        sb_q.push_back(w.exp);
        for (int p = 0; p < N; p++) begin
            key_valid = w.vld[p];
            key_code  = w.code[p];
            key_break = w.brk[p];
            if (p != 0) begin
                chk($sformatf("win%0d gap%0d step", idx, p), int'(step), 0);
                chk($sformatf("win%0d gap%0d dir", idx, p),
                    int'(direction), int'(WAIT));
            end
            nxt();
        end
        key_valid = 1'b0;
        key_break = 1'b0;
        key_code  = 8'h00;
        chk($sformatf("win%0d step", idx), int'(step), 1);
        if (sb_q.size() == 0) begin
            chk($sformatf("win%0d sb empty", idx), 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk($sformatf("win%0d dir", idx), int'(direction), int'(e));
            chk($sformatf("win%0d heading", idx), int'(heading), int'(e));
        end
    endtask

    initial begin
        tbl[0]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, RIGHT);
        tbl[1]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, RIGHT);
        tbl[2]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, RIGHT);
        tbl[3]  = mk(4'b0010, 4'b0000, 0, KU, 0, 0, UP);
        tbl[4]  = mk(4'b0010, 4'b0000, 0, KD, 0, 0, UP);
        tbl[5]  = mk(4'b0110, 4'b0010, 0, KL, KX, 0, UP);
        tbl[6]  = mk(4'b0100, 4'b0000, 0, 0, KR, 0, RIGHT);
        tbl[7]  = mk(4'b0110, 4'b0000, 0, KU, KL, 0, UP);
        tbl[8]  = mk(4'b0010, 4'b0000, 0, KL, 0, 0, LEFT);
        tbl[9]  = mk(4'b0110, 4'b0000, 0, KU, KD, 0, DOWN);
        tbl[10] = mk(4'b1000, 4'b0000, 0, 0, 0, KR, RIGHT);
        tbl[11] = mk(4'b1000, 4'b0000, 0, 0, 0, KU, UP);
        tbl[12] = mk(4'b0010, 4'b0000, 0, KR, 0, 0, RIGHT);
        tbl[13] = mk(4'b1000, 4'b1000, 0, 0, 0, KU, RIGHT);
        tbl[14] = mk(4'b1000, 4'b0000, 0, 0, 0, KL, RIGHT);
        tbl[15] = mk(4'b1010, 4'b0000, 0, KU, 0, KL, UP);
        tbl[16] = mk(4'b0001, 4'b0000, KD, 0, 0, 0, UP);
        tbl[17] = mk(4'b0001, 4'b0000, KL, 0, 0, 0, LEFT);

        rst         = 1'b1;
        game_active = 1'b0;
        key_valid   = 1'b0;
        key_code    = 8'h00;
        key_break   = 1'b0;
        collision   = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;
        chk("reset dir", int'(direction), int'(WAIT));
        chk("reset step", int'(step), 0);
        chk("reset heading", int'(heading), int'(RIGHT));
        chk("reset halted", int'(halted), 0);

        // Idle: keys have no effect and nothing steps
        key_valid = 1'b1;
        key_code  = KU;
        for (int i = 0; i < 6; i++) begin
            nxt();
            chk("idle step", int'(step), 0);
            chk("idle heading", int'(heading), int'(RIGHT));
        end
        key_valid = 1'b0;

        game_active = 1'b1;
        nxt();
        for (int i = 0; i < 18; i++) begin
            run_window(tbl[i], i);
        end

        // Collision on the terminal-count cycle (heading LEFT)
        for (int p = 0; p < N - 1; p++) begin
            nxt();
        end
        collision = 1'b1;
        nxt();
        collision = 1'b0;
        chk("col dir", int'(direction), int'(WAIT));
        chk("col step", int'(step), 0);
        chk("col halted", int'(halted), 1);
        chk("col heading", int'(heading), int'(LEFT));
        key_valid = 1'b1;
        key_code  = KU;
        for (int i = 0; i < 20; i++) begin
            nxt();
            chk("halt step", int'(step), 0);
            chk("halt halted", int'(halted), 1);
        end
        key_valid   = 1'b0;
        game_active = 1'b0;
        nxt();
        chk("exit halted", int'(halted), 0);
        chk("exit heading", int'(heading), int'(RIGHT));
        chk("exit dir", int'(direction), int'(WAIT));

        // Reset at counter==2 with pending UP
        game_active = 1'b1;
        nxt();
        nxt();
        key_valid = 1'b1;
        key_code  = KU;
        nxt();
        key_valid = 1'b0;
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        chk("rst dir", int'(direction), int'(WAIT));
        chk("rst step", int'(step), 0);
        chk("rst heading", int'(heading), int'(RIGHT));
        chk("rst halted", int'(halted), 0);
        nxt();
        run_window(mk(4'b0000, 4'b0000, 0, 0, 0, 0, RIGHT), 99);

        chk("sb drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
